fight_match_controller: RTL and testbench
=========================================

# fight_match_controller

Match-level sequencer in front of the `fightingGame` core. Collects one action per round-step from each player through valid/ready handshakes, applies timeouts, and drives the core's `action1`/`action2`/`actionEnable` with one-cycle issue pulses. It reads the core's `firstWin`/`secondWin` flags, keeps a best-of-N round score, and clears the core between rounds via `roundReset`.

## Interface
- `ROUNDS_TO_WIN`, default 2, round wins needed to take the match; legal range 1..3.
- `ACTION_TIMEOUT`, default 15, cycles spent in COLLECT before missing actions are substituted; legal range 1..255.
- `clk`  in  1  system clock, rising edge.
- `resetGame`  in  1  reset, asynchronous, active-high.
- `startMatch`  in  1  start request; honoured only in IDLE and DONE.
- `p1Valid`, `p2Valid`  in  1  player action offered.
- `p1Action`, `p2Action`  in  3  player action code, passed to the core unmodified.
- `p1Ready`, `p2Ready`  out  1  controller will accept that player's action this cycle.
- `firstWin`, `secondWin`  in  1  round-over flags from the core.
- `action1`, `action2`  out  3  actions driven to the core.
- `actionEnable`  out  1  one-cycle issue strobe to the core.
- `roundReset`  out  1  one-cycle clear to the core, active-high.
- `wins1`, `wins2`  out  2  round wins this match.
- `roundNum`  out  3  completed decisive-or-draw rounds this match, saturating at 7.
- `matchWinner`  out  2  00 none, 01 player 1, 10 player 2.
- `matchDone`  out  1  match finished.
- `busy`  out  1  high in every state except IDLE and DONE.

## Operation
- State machine: IDLE, CLEAR, COLLECT, ISSUE, SETTLE, ROUND_END, DONE.
- IDLE -> CLEAR on `startMatch`. This transition clears `wins1`, `wins2`, `roundNum` and `matchWinner`.
- DONE -> CLEAR on `startMatch`, with the same clearing. In every other state, `startMatch` is ignored.
- CLEAR: `roundReset`=1 for exactly one cycle. Clears both per-player latched flags and the timeout counter. Goes to COLLECT.
- COLLECT:
  - `pNReady` = 1 while that player's flag is clear.
  - A transfer occurs when `pNValid` and `pNReady` are both high on a rising edge. It latches `pNAction` and sets the flag.
  - Both players may transfer on the same edge.
  - The timeout counter increments every COLLECT cycle.
  - Exit to ISSUE when both flags are set, or when the counter reaches `ACTION_TIMEOUT`-1. On timeout, any unlatched player's action is forced to 3'b000. A transfer on the timeout edge is still accepted.
- ISSUE: `actionEnable`=1 for one cycle. `action1`/`action2` carry the latched values. Goes to SETTLE.
- SETTLE: one cycle for the core to register results. At the end of the cycle, sample `firstWin`/`secondWin`.
  - Either flag high -> ROUND_END.
  - Neither high -> COLLECT, clearing the player flags and the counter (the next step in the same round).
- ROUND_END (one cycle):
  - Only `firstWin`: `wins1`++.
  - Only `secondWin`: `wins2`++.
  - Both: draw round, no score change.
  - `roundNum`++ in all cases, saturating at 7.
  - If the updated `wins1` or `wins2` equals `ROUNDS_TO_WIN`, set `matchWinner` and go to DONE; otherwise go to CLEAR.
- DONE: `matchDone`=1 and all scores hold until `startMatch`.
- `action1`/`action2` hold their last issued values outside ISSUE. They are 0 after reset.
- `p1Ready`/`p2Ready` are 0 in every state except COLLECT.

## Timing
- All outputs are registered or are decoded directly from the state register; there are no combinational paths from inputs to outputs.
- Reset values: state IDLE; all outputs 0, including `roundReset`; latched actions 0; counter 0.
- When `resetGame` asserts mid-match, the block immediately returns to IDLE and all outputs go to 0. A pending `actionEnable` is dropped.
- Latency with both players valid on the first COLLECT cycle: ISSUE follows 1 cycle later, so `actionEnable` is high 2 cycles after CLEAR.
- Worst-case latency from COLLECT entry to `actionEnable` is `ACTION_TIMEOUT` cycles.
- A round step takes 3 cycles minimum: COLLECT, ISSUE, SETTLE.
- From `startMatch` sampled to the first `actionEnable` is 3 cycles minimum: CLEAR, COLLECT, ISSUE.
- `matchDone` rises on the cycle after ROUND_END.

## Test plan
- Reset mid-COLLECT, with `p1` latched: assert `resetGame` asynchronously -> all outputs 0 before the next edge. After release, the block sits in IDLE with `busy`=0 until `startMatch`.
- Nominal step: `startMatch`, then `p1Action`=3'b110 and `p2Action`=3'b100, both valid -> `roundReset` pulse, a one-cycle `actionEnable` with `action1`=110 and `action2`=100, then a return to COLLECT with no score change.
- Timeout: `p1Action`=3'b001 offered, `p2` silent, `ACTION_TIMEOUT`=15 -> `actionEnable` high 15 cycles after COLLECT entry, with `action1`=001 and `action2`=000. `p2Ready` drops to 0 after the issue.
- Match win: core model raises `firstWin` after the 1st and 3rd issues, and `secondWin` after the 2nd -> scores 1-0, 1-1, then 2-1. `matchWinner`=01, `matchDone`=1, `roundNum`=3, and `roundReset` pulses exactly twice after the initial CLEAR.
- Draw round: `firstWin` and `secondWin` both high in SETTLE -> `wins` unchanged, `roundNum`++, next state CLEAR.
- Restart: `startMatch` in DONE -> scores, `roundNum` and `matchWinner` clear to 0, and a new CLEAR pulse follows. `startMatch` asserted during COLLECT is ignored.

Source files
------------

// File: rtl/fight_match_controller.sv
// Match sequencer for the fightingGame core: gathers one action per player per step,
// issues them with a one-cycle strobe, and keeps a best-of-N round score.
module fight_match_controller #(
   parameter int ROUNDS_TO_WIN  = 2,
   parameter int ACTION_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       resetGame,
   input  logic       startMatch,
   input  logic       p1Valid,
   input  logic       p2Valid,
   input  logic [2:0] p1Action,
   input  logic [2:0] p2Action,
   output logic       p1Ready,
   output logic       p2Ready,
   input  logic       firstWin,
   input  logic       secondWin,
   output logic [2:0] action1,
   output logic [2:0] action2,
   output logic       actionEnable,
   output logic       roundReset,
   output logic [1:0] wins1,
   output logic [1:0] wins2,
   output logic [2:0] roundNum,
   output logic [1:0] matchWinner,
   output logic       matchDone,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CLEAR     = 3'd1,
      COLLECT   = 3'd2,
      ISSUE     = 3'd3,
      SETTLE    = 3'd4,
      ROUND_END = 3'd5,
      DONE      = 3'd6
   } state_t;

   localparam logic [7:0] TIMEOUT_LAST = 8'(ACTION_TIMEOUT - 1);
   localparam logic [1:0] WIN_TARGET   = 2'(ROUNDS_TO_WIN);

   state_t     state_r, state_s;
   logic       p1_flag_r, p2_flag_r;
   logic [2:0] p1_act_r, p2_act_r;
   logic [7:0] cnt_r;
   logic       fw_r, sw_r;

   logic       p1_xfer_s, p2_xfer_s;
   logic       p1_flag_s, p2_flag_s;
   logic       p1_nflag_s, p2_nflag_s;
   logic [2:0] p1_act_s, p2_act_s;
   logic       timeout_s;
   logic [1:0] wins1_s, wins2_s;
   logic       win1_s, win2_s;

   // Handshake bookkeeping, score preview and next-state selection
   always_comb begin
      p1_xfer_s  = p1Valid & p1Ready;
      p2_xfer_s  = p2Valid & p2Ready;
      p1_flag_s  = p1_flag_r | p1_xfer_s;
      p2_flag_s  = p2_flag_r | p2_xfer_s;
      p1_act_s   = p1_xfer_s ? p1Action : p1_act_r;
      p2_act_s   = p2_xfer_s ? p2Action : p2_act_r;
      // Flags only survive while staying in COLLECT; every COLLECT entry starts clean.
      p1_nflag_s = (state_r == COLLECT) ? p1_flag_s : 1'b0;
      p2_nflag_s = (state_r == COLLECT) ? p2_flag_s : 1'b0;
      timeout_s  = (cnt_r == TIMEOUT_LAST);
      wins1_s    = wins1 + {1'b0, fw_r & ~sw_r};
      wins2_s    = wins2 + {1'b0, sw_r & ~fw_r};
      win1_s     = (wins1_s == WIN_TARGET);
      win2_s     = (wins2_s == WIN_TARGET);
      state_s    = state_r;
      case (state_r)
         IDLE, DONE: begin
            if (startMatch) state_s = CLEAR;
            else            state_s = state_r;
         end
         CLEAR:   state_s = COLLECT;
         COLLECT: begin
            if ((p1_flag_s && p2_flag_s) || timeout_s) state_s = ISSUE;
            else                                       state_s = COLLECT;
         end
         ISSUE:   state_s = SETTLE;
         SETTLE: begin
            if (firstWin || secondWin) state_s = ROUND_END;
            else                       state_s = COLLECT;
         end
         ROUND_END: begin
            if (win1_s || win2_s) state_s = DONE;
            else                  state_s = CLEAR;
         end
         default: state_s = IDLE;
      endcase
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk or posedge resetGame) begin
      if (resetGame) begin
         state_r      <= IDLE;
         p1_flag_r    <= 1'b0;
         p2_flag_r    <= 1'b0;
         p1_act_r     <= 3'b000;
         p2_act_r     <= 3'b000;
         cnt_r        <= 8'd0;
         fw_r         <= 1'b0;
         sw_r         <= 1'b0;
         p1Ready      <= 1'b0;
         p2Ready      <= 1'b0;
         action1      <= 3'b000;
         action2      <= 3'b000;
         actionEnable <= 1'b0;
         roundReset   <= 1'b0;
         wins1        <= 2'd0;
         wins2        <= 2'd0;
         roundNum     <= 3'd0;
         matchWinner  <= 2'b00;
         matchDone    <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state_r      <= state_s;
         p1_flag_r    <= p1_nflag_s;
         p2_flag_r    <= p2_nflag_s;
         p1_act_r     <= p1_act_s;
         p2_act_r     <= p2_act_s;
         cnt_r        <= (state_r == COLLECT) ? cnt_r + 8'd1 : 8'd0;
         p1Ready      <= (state_s == COLLECT) && !p1_nflag_s;
         p2Ready      <= (state_s == COLLECT) && !p2_nflag_s;
         actionEnable <= (state_s == ISSUE);
         roundReset   <= (state_s == CLEAR);
         matchDone    <= (state_s == DONE);
         busy         <= (state_s != IDLE) && (state_s != DONE);
         case (state_r)
            IDLE, DONE: begin
               if (startMatch) begin
                  wins1       <= 2'd0;
                  wins2       <= 2'd0;
                  roundNum    <= 3'd0;
                  matchWinner <= 2'b00;
               end
            end
            COLLECT: begin
               // A player still unlatched at issue time plays the neutral action.
               if (state_s == ISSUE) begin
                  action1 <= p1_flag_s ? p1_act_s : 3'b000;
                  action2 <= p2_flag_s ? p2_act_s : 3'b000;
               end
            end
            SETTLE: begin
               fw_r <= firstWin;
               sw_r <= secondWin;
            end
            ROUND_END: begin
               wins1    <= wins1_s;
               wins2    <= wins2_s;
               roundNum <= (roundNum == 3'd7) ? 3'd7 : roundNum + 3'd1;
               if (win1_s)      matchWinner <= 2'b01;
               else if (win2_s) matchWinner <= 2'b10;
               else             matchWinner <= matchWinner;
            end
            default: begin
               fw_r <= fw_r;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fight_match_controller.sv
// Directed bench for fight_match_controller: a cycle table for the nominal flow,
// then hand sequences for timeout, draw, match win, restart and async reset.
module tb_fight_match_controller;

   logic       clk = 1'b0;
   logic       resetGame, startMatch;
   logic       p1Valid, p2Valid;
   logic [2:0] p1Action, p2Action;
   logic       p1Ready, p2Ready;
   logic       firstWin, secondWin;
   logic [2:0] action1, action2;
   logic       actionEnable, roundReset;
   logic [1:0] wins1, wins2;
   logic [2:0] roundNum;
   logic [1:0] matchWinner;
   logic       matchDone, busy;

   int checks   = 0;
   int failures = 0;
   int rr_count = 0;

   fight_match_controller #(.ROUNDS_TO_WIN(2), .ACTION_TIMEOUT(15)) dut (
      .clk(clk), .resetGame(resetGame), .startMatch(startMatch),
      .p1Valid(p1Valid), .p2Valid(p2Valid), .p1Action(p1Action), .p2Action(p2Action),
      .p1Ready(p1Ready), .p2Ready(p2Ready), .firstWin(firstWin), .secondWin(secondWin),
      .action1(action1), .action2(action2), .actionEnable(actionEnable),
      .roundReset(roundReset), .wins1(wins1), .wins2(wins2), .roundNum(roundNum),
      .matchWinner(matchWinner), .matchDone(matchDone), .busy(busy)
   );

   always #5 clk = ~clk;

   // Count roundReset pulses, sampled mid-cycle
   always @(negedge clk) begin
      if (roundReset) rr_count <= rr_count + 1;
   end

   typedef struct {
      string      nm;
      logic       start;
      logic       p1v;
      logic [2:0] p1a;
      logic       p2v;
      logic [2:0] p2a;
      logic       fw;
      logic       sw;
      logic [20:0] exp;
   } vec_t;

   vec_t vecs[12];

   function automatic logic [20:0] mk(input logic r1, r2, ae, rr, input logic [2:0] a1, a2,
                                      input logic [1:0] w1, w2, input logic [2:0] rn,
                                      input logic [1:0] mw, input logic dn, bz);
      return {r1, r2, ae, rr, a1, a2, w1, w2, rn, mw, dn, bz};
   endfunction

   function automatic logic [20:0] outs();
      return {p1Ready, p2Ready, actionEnable, roundReset, action1, action2,
              wins1, wins2, roundNum, matchWinner, matchDone, busy};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One round step from COLLECT with both players valid; core reports fw/sw in SETTLE.
   task automatic step(input logic [2:0] a1, input logic [2:0] a2, input logic fw,
                       input logic sw, input string nm);
      p1Valid = 1'b1; p1Action = a1;
      p2Valid = 1'b1; p2Action = a2;
      tick();
      chk({nm, "_issue"}, {28'd0, actionEnable, action1, action2} , {28'd0, 1'b1, a1, a2});
      p1Valid = 1'b0; p2Valid = 1'b0;
      firstWin = fw; secondWin = sw;
      tick();
      tick();
      firstWin = 1'b0; secondWin = 1'b0;
      if (fw || sw) tick();
      if ((fw || sw) && !matchDone) tick();
   endtask

   int n;
   int rr_base;

   initial begin
      vecs[0]  = '{"idle",      1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, mk(0,0,0,0,3'd0,3'd0,2'd0,2'd0,3'd0,2'd0,0,0)};
      vecs[1]  = '{"start",     1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, mk(0,0,0,1,3'd0,3'd0,2'd0,2'd0,3'd0,2'd0,0,1)};
      vecs[2]  = '{"collect",   1'b0, 1'b1, 3'd6, 1'b1, 3'd4, 1'b0, 1'b0, mk(1,1,0,0,3'd0,3'd0,2'd0,2'd0,3'd0,2'd0,0,1)};
      vecs[3]  = '{"issue",     1'b0, 1'b1, 3'd6, 1'b1, 3'd4, 1'b0, 1'b0, mk(0,0,1,0,3'd6,3'd4,2'd0,2'd0,3'd0,2'd0,0,1)};
      vecs[4]  = '{"settle",    1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, mk(0,0,0,0,3'd6,3'd4,2'd0,2'd0,3'd0,2'd0,0,1)};
      vecs[5]  = '{"next_step", 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, mk(1,1,0,0,3'd6,3'd4,2'd0,2'd0,3'd0,2'd0,0,1)};
      vecs[6]  = '{"start_ign", 1'b1, 1'b1, 3'd1, 1'b0, 3'd0, 1'b0, 1'b0, mk(0,1,0,0,3'd6,3'd4,2'd0,2'd0,3'd0,2'd0,0,1)};
      vecs[7]  = '{"issue2",    1'b0, 1'b0, 3'd0, 1'b1, 3'd3, 1'b0, 1'b0, mk(0,0,1,0,3'd1,3'd3,2'd0,2'd0,3'd0,2'd0,0,1)};
      vecs[8]  = '{"settle2",   1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0, mk(0,0,0,0,3'd1,3'd3,2'd0,2'd0,3'd0,2'd0,0,1)};
      vecs[9]  = '{"round_end", 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0, mk(0,0,0,0,3'd1,3'd3,2'd0,2'd0,3'd0,2'd0,0,1)};
      vecs[10] = '{"clear2",    1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, mk(0,0,0,1,3'd1,3'd3,2'd1,2'd0,3'd1,2'd0,0,1)};
      vecs[11] = '{"collect2",  1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, mk(1,1,0,0,3'd1,3'd3,2'd1,2'd0,3'd1,2'd0,0,1)};

      resetGame = 1'b1; startMatch = 1'b0;
      p1Valid = 1'b0; p2Valid = 1'b0; p1Action = 3'd0; p2Action = 3'd0;
      firstWin = 1'b0; secondWin = 1'b0;
      tick();
      tick();
      chk("reset_outs", {11'd0, outs()}, 32'd0);
      resetGame = 1'b0;

      for (int i = 0; i < 12; i++) begin
         startMatch = vecs[i].start;
         p1Valid = vecs[i].p1v; p1Action = vecs[i].p1a;
         p2Valid = vecs[i].p2v; p2Action = vecs[i].p2a;
         firstWin = vecs[i].fw; secondWin = vecs[i].sw;
         tick();
         chk(vecs[i].nm, {11'd0, outs()}, {11'd0, vecs[i].exp});
      end
      startMatch = 1'b0; firstWin = 1'b0; secondWin = 1'b0;
      p1Valid = 1'b0; p2Valid = 1'b0;

      // Timeout: p1 offers 001 on COLLECT entry, p2 stays silent
      p1Valid = 1'b1; p1Action = 3'b001;
      tick();
      p1Valid = 1'b0;
      chk("timeout_ready", {30'd0, p1Ready, p2Ready}, 32'b01);
      n = 1;
      while (!actionEnable && n < 40) begin
         tick();
         n++;
      end
      chk("timeout_latency", n, 15);
      chk("timeout_actions", {25'd0, p2Ready, action1, action2}, {25'd0, 1'b0, 3'b001, 3'b000});

      // Draw round straight after the timed-out issue
      firstWin = 1'b1; secondWin = 1'b1;
      tick();
      chk("timeout_p2ready_low", {31'd0, p2Ready}, 32'd0);
      tick();
      firstWin = 1'b0; secondWin = 1'b0;
      tick();
      chk("draw_clear", {24'd0, roundReset, wins1, wins2, roundNum}, {24'd0, 1'b1, 2'd1, 2'd0, 3'd2});
      tick();

      step(3'd2, 3'd5, 1'b1, 1'b0, "first_match_win");
      chk("first_match_done", {21'd0, matchDone, matchWinner, wins1, wins2, roundNum, busy},
          {21'd0, 1'b1, 2'b01, 2'd2, 2'd0, 3'd3, 1'b0});

      // Restart from DONE
      startMatch = 1'b1;
      tick();
      startMatch = 1'b0;
      chk("restart_clear", {21'd0, roundReset, wins1, wins2, roundNum, matchWinner, matchDone, busy},
          {21'd0, 1'b1, 2'd0, 2'd0, 3'd0, 2'b00, 1'b0, 1'b1});
      tick();
      rr_base = rr_count;

      step(3'd6, 3'd4, 1'b1, 1'b0, "m_r1");
      chk("score_1_0", {25'd0, wins1, wins2, roundNum}, {25'd0, 2'd1, 2'd0, 3'd1});
      step(3'd1, 3'd1, 1'b0, 1'b1, "m_r2");
      chk("score_1_1", {25'd0, wins1, wins2, roundNum}, {25'd0, 2'd1, 2'd1, 3'd2});
      step(3'd3, 3'd2, 1'b1, 1'b0, "m_r3");
      chk("score_2_1", {22'd0, matchDone, matchWinner, wins1, wins2, roundNum},
          {22'd0, 1'b1, 2'b01, 2'd2, 2'd1, 3'd3});
      chk("round_reset_pulses", rr_count - rr_base, 2);
      tick();
      chk("done_hold", {22'd0, matchDone, matchWinner, wins1, wins2, roundNum},
          {22'd0, 1'b1, 2'b01, 2'd2, 2'd1, 3'd3});

      // Async reset mid-COLLECT with p1 latched
      startMatch = 1'b1;
      tick();
      startMatch = 1'b0;
      tick();
      p1Valid = 1'b1; p1Action = 3'd5;
      tick();
      p1Valid = 1'b0;
      chk("p1_latched", {30'd0, p1Ready, p2Ready}, 32'b01);
      #2 resetGame = 1'b1;
      #1 chk("async_reset_outs", {11'd0, outs()}, 32'd0);
      tick();
      resetGame = 1'b0;
      tick();
      tick();
      chk("post_reset_idle", {11'd0, outs()}, 32'd0);
      startMatch = 1'b1;
      tick();
      startMatch = 1'b0;
      chk("post_reset_start", {30'd0, roundReset, busy}, 32'b11);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
